// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard/status inputs and stage control strobes between the datapath and the pipeline controller
interface pipeline_ctrl_if;
    logic ihit, dhit, mem_dREN, mem_dWEN, ex_dREN;
    logic [4:0] ex_wsel, id_rs, id_rt;
    logic id_uses_rt, id_halt, redirect, wb_halt;
    logic en_ifid, en_idex, en_exmem, en_memwb;
    logic flush_ifid, flush_idex, flush_exmem;
    logic pc_en, iREN, halted;
    modport master (
        output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel, id_rs, id_rt,
               id_uses_rt, id_halt, redirect, wb_halt,
        input  en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex,
               flush_exmem, pc_en, iREN, halted
    );
    modport slave (
        input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel, id_rs, id_rt,
               id_uses_rt, id_halt, redirect, wb_halt,
        output en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex,
               flush_exmem, pc_en, iREN, halted
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: per-stage enable/flush, PC/fetch enables and halt sequencing for the five-stage pipeline
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    pipeline_ctrl_if.slave   cif,
    output logic [CNT_W-1:0] stall_count
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;
    state_t state, next_state;
    logic ret, next_ret;
    logic memstall, loaduse, stall, drain, go;

    assign memstall = (cif.mem_dREN | cif.mem_dWEN) & ~cif.dhit;
    assign loaduse = cif.ex_dREN & (cif.ex_wsel != 5'd0) &
                     ((cif.ex_wsel == cif.id_rs) | (cif.id_uses_rt & (cif.ex_wsel == cif.id_rt)));
    // Once waiting, only dhit ends the stall; ret says whether we were draining a halt
    assign stall = (state == MEM_WAIT) ? ~cif.dhit : memstall;
    assign drain = (state == DRAIN) | ((state == MEM_WAIT) & ret);
    assign go = nRST & (state != HALTED) & ~stall;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= RUN;
            ret <= 1'b0;
        end else begin
            state <= next_state;
            ret <= next_ret;
        end
    end

    always_comb begin
        next_state = state;
        next_ret = drain;
        if (state != HALTED)
            // wb_halt is older than anything redirecting in MEM, so it wins the transition
            next_state = stall ? MEM_WAIT :
                         cif.wb_halt ? HALTED :
                         cif.redirect ? RUN :
                         (drain | (cif.id_halt & ~loaduse & cif.ihit)) ? DRAIN : RUN;
    end

    always_comb begin
        cif.en_idex = go;
        cif.en_exmem = go;
        cif.en_memwb = go;
        cif.en_ifid = go & (cif.redirect | ~loaduse);
        cif.flush_ifid = go & (cif.redirect | (~loaduse & (~cif.ihit | drain)));
        cif.flush_idex = go & (cif.redirect | loaduse);
        cif.flush_exmem = go & cif.redirect;
        cif.pc_en = go & (cif.redirect | (~loaduse & cif.ihit & ~drain));
        cif.iREN = nRST & (state != HALTED) & (~drain | (cif.redirect & ~stall));
        cif.halted = nRST & (state == HALTED);
    end

    always_ff @(posedge CLK) begin
        if (!nRST)
            stall_count <= '0;
        else if (!cif.pc_en && state != HALTED && !(&stall_count))
            stall_count <= stall_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed plus randomized checks of pipeline_ctrl against a priority-rule reference model
module tb_pipeline_ctrl;
    logic CLK = 1'b0;
    logic nRST;
    logic [31:0] stall_count;
    logic [3:0] stall_count4;
    int checks = 0;
    int errors = 0;

    pipeline_ctrl_if cif ();
    pipeline_ctrl_if cif4 ();

    pipeline_ctrl #(.CNT_W(32)) dut (.CLK(CLK), .nRST(nRST), .cif(cif.slave), .stall_count(stall_count));
    pipeline_ctrl #(.CNT_W(4)) dut4 (.CLK(CLK), .nRST(nRST), .cif(cif4.slave), .stall_count(stall_count4));

    assign cif4.ihit = cif.ihit;
    assign cif4.dhit = cif.dhit;
    assign cif4.mem_dREN = cif.mem_dREN;
    assign cif4.mem_dWEN = cif.mem_dWEN;
    assign cif4.ex_dREN = cif.ex_dREN;
    assign cif4.ex_wsel = cif.ex_wsel;
    assign cif4.id_rs = cif.id_rs;
    assign cif4.id_rt = cif.id_rt;
    assign cif4.id_uses_rt = cif.id_uses_rt;
    assign cif4.id_halt = cif.id_halt;
    assign cif4.redirect = cif.redirect;
    assign cif4.wb_halt = cif.wb_halt;

    always #5 CLK = ~CLK;

    // Reference model: halted / waiting-on-dmem / draining-a-halt flags and the two counters
    logic m_halted, m_wait, m_drain;
    longint m_cnt, m_cnt4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        cif.ihit = 1; cif.dhit = 1; cif.mem_dREN = 0; cif.mem_dWEN = 0; cif.ex_dREN = 0;
        cif.ex_wsel = 0; cif.id_rs = 0; cif.id_rt = 0; cif.id_uses_rt = 0;
        cif.id_halt = 0; cif.redirect = 0; cif.wb_halt = 0;
    endtask

    // One clock: evaluate expected outputs at the falling edge, compare, then advance the model at the rising edge
    task automatic cycle(input string tag);
        logic lu, ms;
        logic [9:0] e, got;
        @(negedge CLK);
        lu = cif.ex_dREN && cif.ex_wsel != 0 &&
             (cif.ex_wsel == cif.id_rs || (cif.id_uses_rt && cif.ex_wsel == cif.id_rt));
        ms = m_wait ? !cif.dhit : ((cif.mem_dREN || cif.mem_dWEN) && !cif.dhit);
        // {en_ifid,en_idex,en_exmem,en_memwb, flush_ifid,flush_idex,flush_exmem, pc_en,iREN,halted}
        if (!nRST) e = 10'b0;
        else if (m_halted) e = 10'b0000_000_001;
        else if (ms) e = {4'b0000, 3'b000, 1'b0, !m_drain, 1'b0};
        else if (cif.redirect) e = {4'b1111, 3'b111, 1'b1, 1'b1, 1'b0};
        else if (lu) e = {4'b0111, 3'b010, 1'b0, !m_drain, 1'b0};
        else if (!cif.ihit || m_drain) e = {4'b1111, 3'b100, 1'b0, !m_drain, 1'b0};
        else e = 10'b1111_000_110;
        got = {cif.en_ifid, cif.en_idex, cif.en_exmem, cif.en_memwb, cif.flush_ifid,
               cif.flush_idex, cif.flush_exmem, cif.pc_en, cif.iREN, cif.halted};
        check({tag, ".out"}, 32'(got), 32'(e));
        check({tag, ".cnt"}, stall_count, 32'(m_cnt));
        check({tag, ".cnt4"}, 32'(stall_count4), 32'(m_cnt4));
        @(posedge CLK);
        if (!nRST) begin
            m_halted = 0; m_wait = 0; m_drain = 0; m_cnt = 0; m_cnt4 = 0;
        end else if (!m_halted) begin
            if (!e[2]) begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (ms) m_wait = 1;
            else begin
                m_wait = 0;
                if (cif.wb_halt) m_halted = 1;
                else if (cif.redirect) m_drain = 0;
                else if (!m_drain && cif.id_halt && !lu && cif.ihit) m_drain = 1;
            end
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        nRST = 0;
        for (int i = 0; i < n; i++) cycle("reset");
        nRST = 1;
    endtask

    initial begin
        m_halted = 0; m_wait = 0; m_drain = 0; m_cnt = 0; m_cnt4 = 0;
        idle();
        nRST = 0;
        @(posedge CLK); #1;
        do_reset(2);
        check("reset_cnt", stall_count, 0);

        // Reset held mid-MEM_WAIT
        cif.mem_dREN = 1; cif.dhit = 0;
        cycle("mw_pre"); cycle("mw_pre");
        do_reset(3);
        idle();
        cycle("mw_after");
        check("mw_after_cnt", stall_count, 0);

        // Load-use hazard, then same with ex_wsel=0
        cif.ex_dREN = 1; cif.ex_wsel = 5; cif.id_rs = 5;
        cycle("loaduse");
        idle(); cycle("lu_done");
        check("lu_cnt", stall_count, 1);
        cif.ex_dREN = 1; cif.ex_wsel = 0; cif.id_rs = 0;
        cycle("lu_r0");
        idle(); cycle("lu_r0_done");

        // Store miss for 4 cycles
        cif.mem_dWEN = 1; cif.dhit = 0;
        for (int i = 0; i < 4; i++) cycle("dmiss");
        cif.dhit = 1; cycle("dhit");
        idle(); cycle("dmiss_done");
        check("dmiss_cnt", stall_count, 5);

        // Redirect with loaduse and icache miss
        cif.redirect = 1; cif.ex_dREN = 1; cif.ex_wsel = 3; cif.id_rt = 3; cif.id_uses_rt = 1; cif.ihit = 0;
        cycle("redir_lu");
        idle(); cycle("redir_done");

        // Halt squashed by a later redirect
        cif.id_halt = 1; cycle("halt_id");
        idle(); cycle("drain1");
        check("drain_iren", cif.iREN, 0);
        cif.redirect = 1; cycle("drain_redir");
        idle(); cycle("drain_back");

        // Halt with memory wait inside drain, then wb_halt
        cif.id_halt = 1; cycle("halt_id2");
        idle(); cif.mem_dREN = 1; cif.dhit = 0; cycle("drain_mw");
        cycle("drain_mw2");
        cif.dhit = 1; cycle("drain_mw_hit");
        idle(); cif.wb_halt = 1; cycle("wb_halt");
        idle();
        for (int i = 0; i < 10; i++) begin
            cif.ihit = 1'($urandom); cif.dhit = 1'($urandom); cif.mem_dREN = 1'($urandom);
            cycle("halted_hold");
        end
        check("halted_sticky", cif.halted, 1);
        idle();

        // Saturation of the narrow counter
        do_reset(1);
        cif.ihit = 0;
        for (int i = 0; i < 20; i++) cycle("sat");
        check("sat4", 32'(stall_count4), 15);
        idle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            nRST = $urandom_range(0, 60) != 0;
            cif.ihit = $urandom_range(0, 5) != 0;
            cif.dhit = $urandom_range(0, 2) != 0;
            cif.mem_dREN = $urandom_range(0, 3) == 0;
            cif.mem_dWEN = $urandom_range(0, 4) == 0;
            cif.ex_dREN = $urandom_range(0, 2) == 0;
            cif.ex_wsel = 5'($urandom_range(0, 3));
            cif.id_rs = 5'($urandom_range(0, 3));
            cif.id_rt = 5'($urandom_range(0, 3));
            cif.id_uses_rt = 1'($urandom);
            cif.id_halt = $urandom_range(0, 7) == 0;
            cif.redirect = $urandom_range(0, 6) == 0;
            cif.wb_halt = $urandom_range(0, 40) == 0;
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencing controller for the five-stage pipeline register bank (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Each cycle it generates per-stage enable and flush strobes and the PC/fetch enables from cache hits, load-use hazards, resolved branches/jumps and halt.
- A small FSM tracks data-memory waits, halt draining and the terminal halted state. A saturating stall counter provides performance visibility.

Parameters:
CNT_W, 32, width of stall_count

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  synchronous active-low reset
ihit  in  1  instruction cache hit this cycle
dhit  in  1  data cache hit this cycle
mem_dREN  in  1  load in MEM stage (EX/MEM output)
mem_dWEN  in  1  store in MEM stage (EX/MEM output)
ex_dREN  in  1  load in EX stage (ID/EX output)
ex_wsel  in  5  destination register of EX-stage instruction
id_rs  in  5  rs field of IF/ID instruction
id_rt  in  5  rt field of IF/ID instruction
id_uses_rt  in  1  IF/ID instruction reads rt
id_halt  in  1  halt decoded in ID
redirect  in  1  branch taken or j/jal/JR resolved in MEM stage
wb_halt  in  1  halt at MEM/WB output
en_ifid, en_idex, en_exmem, en_memwb  out  1 each  stage register load enables
flush_ifid, flush_idex, flush_exmem  out  1 each  load bubble (flush overrides enable)
pc_en  out  1  PC update enable
iREN  out  1  instruction fetch request
halted  out  1  CPU halted
stall_count  out  CNT_W  cycles with pc_en low, excluding reset and HALTED

Behaviour:
- Reset: nRST sampled on the CLK rising edge only; no asynchronous path. Reset gives state=RUN and stall_count=0.
- While nRST is low, outputs are forced: all en_* 0, all flush_* 0, pc_en 0, iREN 0, halted 0. A reset issued in any state, including mid-MEM_WAIT or HALTED, returns the block to RUN on the next edge.
- Outputs are combinational from state and inputs. Defaults: all en_* 1, flush_* 0, pc_en 1, iREN 1, halted 0.
- memstall = (mem_dREN | mem_dWEN) & ~dhit.
- loaduse = ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)).
- Priority, highest first: HALTED > memstall > redirect > loaduse > ~ihit > DRAIN gating.

States:
- RUN:
  - memstall: all en_* 0, pc_en 0; next state MEM_WAIT.
  - redirect: flush_ifid, flush_idex and flush_exmem = 1; pc_en 1 (PC loads target), regardless of ihit.
  - loaduse: en_ifid 0, pc_en 0, flush_idex 1; EX/MEM and MEM/WB advance. Exactly one bubble per hazard.
  - ~ihit: pc_en 0, flush_ifid 1; downstream stages advance.
  - id_halt with none of the above: next state DRAIN. The halt itself advances normally.
  - wb_halt: next state HALTED.
- MEM_WAIT:
  - dhit low: all en_* 0, pc_en 0.
  - dhit high: apply the RUN rules for this cycle and return to RUN. No extra bubble is inserted.
- DRAIN:
  - pc_en 0, iREN 0, flush_ifid 1; remaining stages advance. memstall handling is identical to RUN (via MEM_WAIT, which then returns to DRAIN).
  - redirect: the halt was on the wrong path; apply the RUN redirect response and go to RUN.
  - wb_halt: go to HALTED.
  - MEM_WAIT remembers its return state (RUN or DRAIN) in 1 bit.
- HALTED: all en_* 0, all flush_* 0, pc_en 0, iREN 0, halted 1. Sticky until reset.
- stall_count: increments by 1 on each cycle with pc_en==0 and state!=HALTED; saturates at all-ones, no wrap.
- Simultaneous events:
  - redirect with loaduse: redirect only, and the stall does not occur.
  - wb_halt with memstall: memstall wins, and wb_halt is re-evaluated once the stall ends.

Test Plan:
- Reset held 3 cycles mid-MEM_WAIT (mem_dREN=1, dhit=0) -> all outputs 0 during reset; state RUN; stall_count 0 afterwards.
- ex_dREN=1, ex_wsel=5, id_rs=5, ihit=1 -> exactly one cycle of en_ifid=0, pc_en=0, flush_idex=1; stall_count +1. Repeat with ex_wsel=0 -> no stall.
- mem_dWEN=1, dhit=0 for 4 cycles, then 1 -> en_* all 0 for 4 cycles, all 1 on the dhit cycle; stall_count +4.
- redirect=1 with loaduse=1 and ihit=0 -> flush_ifid, flush_idex and flush_exmem = 1, pc_en=1, no stall.
- id_halt=1, then redirect 2 cycles later -> DRAIN (iREN=0) for 2 cycles, then RUN with flushes. Re-run without redirect and pulse wb_halt -> halted=1 persists for 10 cycles despite ihit/dhit toggling.
- Force stall_count to saturation via 2^CNT_W-1 stalls (CNT_W=4 instance: 15) -> holds at 15 on further stalls.
